// File: rtl/riscv_pkg.sv
// Shared encodings for the control decoder and the load/store unit.
// Access size codes and a misalignment helper live here too.
package riscv_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        SB   = 2'b01,
        SH   = 2'b10,
        SW   = 2'b11
    } mem_write_e;

    typedef enum logic [2:0] {
        LW  = 3'b000,
        LB  = 3'b001,
        LH  = 3'b010,
        LBU = 3'b101,
        LHU = 3'b110
    } extend_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        return (size == SZ_H && off[0]) ||
               (size == SZ_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed lanes out of a bus word and extends them
// to 32 bits; unknown extend codes pass the shifted word through.
module load_extender
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  extend,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // sign/zero extension of the low byte or halfword
    always_comb begin
        result = shifted;
        case (extend)
            LB:      result = {{24{shifted[7]}}, shifted[7:0]};
            LH:      result = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     result = {24'b0, shifted[7:0]};
            LHU:     result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: steers store lanes, runs a req/gnt/rvalid
// transaction with timeout and stalls the core until it completes.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic [1:0]  memory_write_i,
    input  logic [2:0]  result_extend_control_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic        stall_o,
    output logic [31:0] read_data_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state, state_next;
    logic [7:0]  cnt;
    logic [1:0]  offset;
    logic [2:0]  ext;
    logic        is_store, access, bad, timeout;
    logic [1:0]  size;
    logic [3:0]  be;
    logic [31:0] wdata, ext_data;

    assign is_store = memory_write_i != NONE;
    assign access   = mem_read_i | is_store;
    assign bad      = access && is_misaligned(size, address_i[1:0]);
    assign timeout  = cnt == LAST;

    load_extender u_ext (
        .rdata  (bus_rdata_i),
        .offset (offset),
        .extend (ext),
        .result (ext_data)
    );

    // access size, byte enables and lane-replicated store data
    always_comb begin
        size  = SZ_W;
        be    = 4'b1111;
        wdata = '0;
        if (is_store) begin
            case (memory_write_i)
                SB: begin
                    size  = SZ_B;
                    be    = 4'b0001 << address_i[1:0];
                    wdata = {4{write_data_i[7:0]}};
                end
                SH: begin
                    size  = SZ_H;
                    be    = address_i[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{write_data_i[15:0]}};
                end
                default: wdata = write_data_i;
            endcase
        end else begin
            case (result_extend_control_i)
                LB, LBU: size = SZ_B;
                LH, LHU: size = SZ_H;
                default: size = SZ_W;
            endcase
        end
    end

    // next state, stall and misalignment pulse
    always_comb begin
        state_next   = state;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        case (state)
            IDLE: begin
                if (access && bad) begin
                    misaligned_o = 1'b1;
                end else if (access) begin
                    stall_o    = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (timeout)        state_next = DONE;
                else if (bus_gnt_i) state_next = WAIT;
            end
            WAIT: begin
                stall_o = 1'b1;
                if (bus_rvalid_i || timeout) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        if (rst_i) begin
            stall_o      = 1'b0;
            misaligned_o = 1'b0;
        end
    end

    // state, timeout counter and registered bus/result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            offset      <= '0;
            ext         <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            read_data_o <= '0;
            bus_error_o <= 1'b0;
        end else begin
            state       <= state_next;
            bus_error_o <= 1'b0;
            if (state == REQ || state == WAIT) cnt <= cnt + 8'd1;
            else                               cnt <= '0;
            case (state)
                IDLE: begin
                    if (state_next == REQ) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_addr_o  <= {address_i[31:2], 2'b00};
                        bus_be_o    <= be;
                        bus_wdata_o <= wdata;
                        offset      <= address_i[1:0];
                        ext         <= is_store ? 3'b000
                                                : result_extend_control_i;
                    end
                end
                REQ: begin
                    if (state_next != REQ) bus_req_o <= 1'b0;
                    if (timeout) begin
                        read_data_o <= '0;
                        bus_error_o <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus_rvalid_i) begin
                        read_data_o <= bus_we_o ? 32'b0 : ext_data;
                    end else if (timeout) begin
                        read_data_o <= '0;
                        bus_error_o <= 1'b1;
                    end
                end
                default: read_data_o <= '0;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage between the decoded core datapath and the data bus.
- Consumes the store-size code (memory_write), load-extend code (result_extend_control) and load-select (result_source) produced by the control decoder, plus ALU address and rs2 data.
- Runs a request/grant/response bus transaction, stalls the single-cycle core until done, and returns the extended load result.
- Performs byte-lane steering, sign/zero extension, misalignment detection and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before abort; range 1..255, 8-bit counter.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous, active-high reset
- mem_read_i  input  1  load instruction present (result_source)
- memory_write_i  input  2  00 none, 01 sb, 10 sh, 11 sw
- result_extend_control_i  input  3  000 lw, 001 lb, 010 lh, 101 lbu, 110 lhu
- address_i  input  32  byte address from ALU
- write_data_i  input  32  rs2 value
- stall_o  output  1  hold PC and register write
- read_data_o  output  32  extended load data, valid when stall_o=0 in DONE
- misaligned_o  output  1  one-cycle pulse, access rejected
- bus_error_o  output  1  one-cycle pulse, timeout abort
- bus_req_o  output  1  request valid
- bus_we_o  output  1  1 = write
- bus_addr_o  output  32  word address, bits [1:0] = 0
- bus_be_o  output  4  byte enables
- bus_wdata_o  output  32  lane-steered store data
- bus_gnt_i  input  1  request accepted
- bus_rvalid_i  input  1  response valid (reads and writes)
- bus_rdata_i  input  32  response data

Behaviour:
- Reset: state IDLE; all outputs 0 (stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, read_data_o, misaligned_o, bus_error_o); timeout counter 0. Reset mid-transaction abandons it; any later bus_rvalid_i is ignored.
- Access = mem_read_i | (memory_write_i != 00). If both are set, the store wins.
- Misaligned:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
  - In IDLE: no bus activity, misaligned_o=1 for that cycle, stall_o=0, read_data_o=0.
- States: IDLE, REQ, WAIT, DONE. All bus outputs are registered.
- IDLE:
  - An aligned access asserts stall_o combinationally the same cycle.
  - It registers addr, offset, size, extend code, be and wdata, then moves to REQ.
- REQ:
  - bus_req_o=1, outputs held stable until bus_gnt_i; stall_o=1.
  - Gnt moves to WAIT and drops bus_req_o next cycle.
- WAIT:
  - stall_o=1. bus_rvalid_i in the same cycle as gnt is not legal and is ignored.
  - rvalid moves to DONE and captures the extended data into read_data_o (stores: 0).
- DONE:
  - stall_o=0 for exactly one cycle; the core retires and advances, then the state returns to IDLE.
  - A new access seen in IDLE next cycle starts fresh.
- Latency: minimum 3 stall cycles (IDLE, REQ, WAIT) plus 1 DONE cycle.
- Timeout:
  - The counter increments each cycle in REQ/WAIT and clears on entering IDLE.
  - On reaching TIMEOUT_CYCLES, go to DONE with read_data_o=0 and bus_error_o pulsed in the DONE cycle; bus_req_o is dropped.
- Store steering:
  - sb: be = 0001 << addr[1:0], wdata = byte replicated x4.
  - sh: be = addr[1] ? 1100 : 0011, wdata = halfword replicated x2.
  - sw: be = 1111.
- Load reads use be=1111. Extraction: shift rdata right by 8*offset, then extend per code (lb/lh sign, lbu/lhu zero, lw pass). Undefined extend codes behave as lw.

Decomposition:
- Shared package riscv_pkg:
  - mem_write_e (NONE, SB, SH, SW);
  - extend_e (LW, LB, LH, LBU, LHU);
  - lsu_state_e (IDLE, REQ, WAIT, DONE).
- The control decoder uses the same encodings.
- One combinational sub-module, load_extender: rdata, offset, extend code -> 32-bit result. The FSM, lane steering and timeout stay in load_store_unit.

Test Plan:
- lw: addr 0x1000_0008, gnt in first REQ cycle, rvalid next cycle with rdata 0xDEAD_BEEF -> bus_addr 0x1000_0008, be 1111, stall high 3 cycles, read_data_o 0xDEAD_BEEF in DONE.
- lb at offset 3 with rdata 0x80FF_1234 -> read_data_o 0xFFFF_FF80; lbu at the same address -> 0x0000_0080; lhu at offset 2 -> 0x0000_80FF.
- sh: addr 0x22, wdata 0x0000_ABCD -> bus_addr 0x20, be 1100, bus_wdata 0xABCD_ABCD, bus_we_o=1; gnt held off 4 cycles -> outputs stable throughout REQ.
- sw to addr 0x1002 -> misaligned_o pulse, bus_req_o stays 0, stall_o 0.
- No rvalid with TIMEOUT_CYCLES=4 -> DONE after 4 REQ/WAIT cycles, bus_error_o pulse, read_data_o 0.
- rst_i during WAIT, then stray rvalid -> state IDLE, stall_o 0, rvalid ignored; next lw completes normally.
